// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and helpers for the AES block/word stream converters.
package aes_stream_pkg;
  function automatic int n_words(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction
  localparam int N_WORDS = n_words(128, 32);
  typedef logic [$clog2(N_WORDS)-1:0] word_idx_t;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/block_serializer.sv
// block_serializer: splits one IN_WIDTH block per handshake into up to N OUT_WIDTH words.
module block_serializer
  import aes_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clr_i,
  input  logic                                     enable_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic [IN_WIDTH-1:0]                      block_i,
  input  logic [$clog2(IN_WIDTH/OUT_WIDTH):0]      nwords_i,
  input  logic                                     last_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic [OUT_WIDTH-1:0]                     word_o,
  output logic                                     last_o
);
  localparam int N  = n_words(IN_WIDTH, OUT_WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, last_idx_q, eff_last, idx;
  logic [IN_WIDTH-1:0] hold_q;
  logic last_q, final_w, in_xfer, out_xfer;
  always_comb begin
    eff_last = (nwords_i == '0 || int'(nwords_i) > N) ? CW'(N - 1) : CW'(int'(nwords_i) - 1);
    final_w  = cnt_q == last_idx_q;
    valid_o  = state_q == SEND;
    ready_o  = enable_i & ((state_q == IDLE) | (valid_o & final_w & ready_i));
    in_xfer  = valid_i & ready_o;
    out_xfer = valid_o & ready_i;
    last_o   = valid_o & last_q & final_w;
    idx      = MSW_FIRST ? CW'(N - 1) - cnt_q : cnt_q;
    word_o   = hold_q[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
    state_d  = in_xfer ? SEND : (out_xfer & final_w) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      hold_q     <= '0;
      last_q     <= 1'b0;
    end else if (clr_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      hold_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // A new block loaded on the final-word transfer restarts the count without a bubble
      if (in_xfer) begin
        hold_q     <= block_i;
        last_idx_q <= eff_last;
        last_q     <= last_i;
        cnt_q      <= '0;
      end else if (out_xfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule
